// File: rtl/pixel_diff_if.sv
// Bundles the joined input streams (A, B) and the result stream of the
// pixel comparator.
//   master : frame-source / display-sink side (drives a_*, b_*, out_ready)
//   slave  : comparator side (drives in_ready, out_*)
// Signals: a_valid/a_sof/a_data, b_valid/b_sof/b_data, in_ready (shared),
//          out_valid/out_ready/out_data/out_sof/out_eol.
interface pixel_diff_if #(
  parameter int DW = 8,
  parameter int CH = 3
);
  logic             a_valid;
  logic             a_sof;
  logic [CH*DW-1:0] a_data;
  logic             b_valid;
  logic             b_sof;
  logic [CH*DW-1:0] b_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [CH*DW-1:0] out_data;
  logic             out_sof;
  logic             out_eol;

  modport master (
    output a_valid, a_sof, a_data, b_valid, b_sof, b_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol
  );

  modport slave (
    input  a_valid, a_sof, a_data, b_valid, b_sof, b_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol
  );
endinterface

// File: rtl/pixel_diff_stream.sv
// Streaming two-frame pixel comparator.
// Joins two lock-step pixel streams, compares them channel by channel against
// a threshold and emits a masked or difference pixel stream, counting the
// differing pixels of every complete frame.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mode         0=A masked, 1=B masked, 2=|A-B|, 3=A whole-pixel masked
//   threshold    channel differs when |A-B| > threshold
//   px           stream interface (slave side)
//   diff_count   differing-pixel count of the last complete frame
//   count_valid  one-cycle pulse when diff_count updates
//   sync_err     sticky flag: a_sof and b_sof disagreed on an accepted beat
module pixel_diff_stream #(
  parameter int            DW    = 8,
  parameter int            CH    = 3,
  parameter int            H_ACT = 640,
  parameter int            V_ACT = 480,
  parameter logic [DW-1:0] FILL  = 8'h80
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          mode,
  input  logic [DW-1:0]                       threshold,
  pixel_diff_if.slave                         px,
  output logic [$clog2(H_ACT*V_ACT+1)-1:0]    diff_count,
  output logic                                count_valid,
  output logic                                sync_err
);
  localparam int PW = CH * DW;
  localparam int CW = $clog2(H_ACT * V_ACT + 1);
  localparam int XW = $clog2(H_ACT + 1);
  localparam int YW = $clog2(V_ACT + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]    stateReg;
  logic [1:0]    modeReg;
  logic [DW-1:0] thrReg;
  logic [XW-1:0] xReg;
  logic [YW-1:0] yReg;
  logic [CW-1:0] runReg;

  logic          accept;
  logic          sofIn;
  logic          emit;
  logic [1:0]    modeEff;
  logic [DW-1:0] thrEff;
  logic [CH-1:0] chDiffers;
  logic [PW-1:0] chanOut;
  logic          pixDiffers;
  logic [PW-1:0] pixOut;
  logic [XW-1:0] xCur;
  logic [YW-1:0] yCur;
  logic [CW-1:0] runBase;
  logic [CW-1:0] runNext;
  logic          atEol;
  logic          atLast;

  // A single output register: an empty slot, or one being drained this
  // cycle, can take a new beat, so full throughput needs no bubble.
  assign px.in_ready = !px.out_valid || px.out_ready;
  assign accept      = px.a_valid && px.b_valid && px.in_ready;
  assign sofIn       = px.a_sof || px.b_sof;

  // A sof beat already uses the new mode/threshold; the rest of the frame
  // uses the copy latched on that beat.
  assign modeEff = sofIn ? mode : modeReg;
  assign thrEff  = sofIn ? threshold : thrReg;

  for (genvar gi = 0; gi < CH; gi++) begin : gCh
    logic [DW-1:0] aCh;
    logic [DW-1:0] bCh;
    logic [DW:0]   sub;
    logic [DW-1:0] absDiff;

    assign aCh     = px.a_data[gi*DW +: DW];
    assign bCh     = px.b_data[gi*DW +: DW];
    assign sub     = {1'b0, aCh} - {1'b0, bCh};
    // Borrow out of the extended subtract means b > a.
    assign absDiff = sub[DW] ? (bCh - aCh) : sub[DW-1:0];
    assign chDiffers[gi] = absDiff > thrEff;

    always_comb begin
      chanOut[gi*DW +: DW] = absDiff;
      case (modeEff)
        2'd0:    chanOut[gi*DW +: DW] = chDiffers[gi] ? aCh : FILL;
        2'd1:    chanOut[gi*DW +: DW] = chDiffers[gi] ? bCh : FILL;
        default: chanOut[gi*DW +: DW] = absDiff;
      endcase
    end
  end

  assign pixDiffers = |chDiffers;
  assign pixOut     = (modeEff == 2'd3) ? (pixDiffers ? px.a_data : {CH{FILL}})
                                        : chanOut;

  // Beats accepted while IDLE without sof are consumed and dropped.
  assign emit = accept && (sofIn || (stateReg == ACTIVE));

  // Any sof (including one mid-frame) restarts position and count.
  assign xCur    = sofIn ? '0 : xReg;
  assign yCur    = sofIn ? '0 : yReg;
  assign runBase = sofIn ? '0 : runReg;
  assign atEol   = (xCur == XW'(H_ACT - 1));
  assign atLast  = atEol && (yCur == YW'(V_ACT - 1));
  assign runNext = (pixDiffers && (runBase != '1)) ? runBase + CW'(1) : runBase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= IDLE;
      modeReg      <= '0;
      thrReg       <= '0;
      xReg         <= '0;
      yReg         <= '0;
      runReg       <= '0;
      px.out_valid <= 1'b0;
      px.out_data  <= '0;
      px.out_sof   <= 1'b0;
      px.out_eol   <= 1'b0;
      diff_count   <= '0;
      count_valid  <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      count_valid <= 1'b0;

      if (accept && (px.a_sof != px.b_sof)) begin
        sync_err <= 1'b1;
      end

      if (px.in_ready) begin
        px.out_valid <= emit;
        if (emit) begin
          px.out_data <= pixOut;
          px.out_sof  <= sofIn;
          px.out_eol  <= atEol;
        end
      end

      if (emit) begin
        if (sofIn) begin
          modeReg <= mode;
          thrReg  <= threshold;
        end
        xReg   <= atEol ? '0 : xCur + XW'(1);
        yReg   <= atEol ? yCur + YW'(1) : yCur;
        runReg <= runNext;
        if (atLast) begin
          diff_count  <= runNext;
          count_valid <= 1'b1;
          stateReg    <= IDLE;
        end else begin
          stateReg <= ACTIVE;
        end
      end
    end
  end
endmodule

// File: tb/tb_pixel_diff_stream.sv
// Self-checking bench for pixel_diff_stream using a reduced 16x8 frame.
// Expected pixels and frame counts are queued when beats are driven and
// compared when the DUT hands them out.
module tb_pixel_diff_stream;
  localparam int DW = 8;
  localparam int CH = 3;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int NP = H * V;
  localparam int PW = CH * DW;
  localparam int CW = $clog2(H * V + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = '0;
  logic [DW-1:0] threshold = '0;
  logic [CW-1:0] diff_count;
  logic          count_valid;
  logic          sync_err;

  pixel_diff_if #(.DW(DW), .CH(CH)) bus ();

  pixel_diff_stream #(
    .DW(DW), .CH(CH), .H_ACT(H), .V_ACT(V), .FILL(8'h80)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .threshold   (threshold),
    .px          (bus.slave),
    .diff_count  (diff_count),
    .count_valid (count_valid),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: {data, sof, eol} per emitted beat and one count per frame.
  logic [PW+1:0] expQ[$];
  logic [CW-1:0] cntQ[$];

  // Reference model state.
  bit         active = 0;
  int         pix = 0;
  int         run = 0;
  logic [1:0] latMode = '0;
  logic [7:0] latThr = '0;
  int         framesDone = 0;
  int         cvSeen = 0;
  int         outIdx = 0;
  bit         stall = 0;

  logic [PW-1:0] aF[NP];
  logic [PW-1:0] bF[NP];

  function automatic logic [7:0] absd(input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? x - y : y - x;
  endfunction

  function automatic bit differs(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [7:0] t);
    bit d = 0;
    for (int c = 0; c < CH; c++) if (absd(a[c*8 +: 8], b[c*8 +: 8]) > t) d = 1;
    return d;
  endfunction

  function automatic logic [PW-1:0] refPixel(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                             input logic [1:0] m, input logic [7:0] t);
    logic [PW-1:0] r;
    r = '0;
    if (m == 2'd3) return differs(a, b, t) ? a : 24'h808080;
    for (int c = 0; c < CH; c++) begin
      logic [7:0] ac, bc, d;
      ac = a[c*8 +: 8];
      bc = b[c*8 +: 8];
      d  = absd(ac, bc);
      case (m)
        2'd0:    r[c*8 +: 8] = (d > t) ? ac : 8'h80;
        2'd1:    r[c*8 +: 8] = (d > t) ? bc : 8'h80;
        default: r[c*8 +: 8] = d;
      endcase
    end
    return r;
  endfunction

  // Output monitor, sampled on the falling edge: a transfer seen here
  // completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkEq("unexpected_out", 64'(bus.out_data), 64'hDEAD);
        end else begin
          logic [PW+1:0] e;
          e = expQ.pop_front();
          checkEq($sformatf("out_data#%0d", outIdx), 64'(bus.out_data), 64'(e[PW+1:2]));
          checkEq($sformatf("out_sof#%0d", outIdx), 64'(bus.out_sof), 64'(e[1]));
          checkEq($sformatf("out_eol#%0d", outIdx), 64'(bus.out_eol), 64'(e[0]));
        end
        outIdx++;
      end
      if (count_valid) begin
        cvSeen++;
        checkEq("cv_on_eol", 64'(bus.out_eol && bus.out_valid), 64'd1);
        if (cntQ.size() == 0) checkEq("unexpected_count_valid", 64'(diff_count), 64'hDEAD);
        else checkEq("diff_count", 64'(diff_count), 64'(cntQ.pop_front()));
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic idleBus();
    bus.a_valid = 0; bus.b_valid = 0; bus.a_sof = 0; bus.b_sof = 0;
  endtask

  // Drive one joined beat, wait for acceptance, update the model.
  task automatic beat(input logic [PW-1:0] a, input logic [PW-1:0] b, input bit as, input bit bs,
                      input logic [1:0] m, input logic [7:0] t);
    int waitCyc = 0;
    bit acc = 0;
    bus.a_valid = 1; bus.b_valid = 1;
    bus.a_data = a; bus.b_data = b; bus.a_sof = as; bus.b_sof = bs;
    mode = m; threshold = t;
    while (!acc && waitCyc < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      waitCyc++;
    end
    if (!acc) begin
      checkEq("accept_timeout", 64'd0, 64'd1);
    end else begin
      if (as || bs) begin
        active = 1; pix = 0; run = 0; latMode = m; latThr = t;
      end
      if (active) begin
        bit d = differs(a, b, latThr);
        expQ.push_back({refPixel(a, b, latMode, latThr), 1'(as || bs), 1'((pix % H) == H - 1)});
        run += int'(d);
        if (pix == NP - 1) begin
          cntQ.push_back(CW'(run));
          framesDone++;
          active = 0;
        end else begin
          pix++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Sends n beats of the frame in aF/bF; mode/threshold inputs are
  // scrambled after the sof beat to show they are held for the frame.
  task automatic sendFrame(input logic [1:0] m, input logic [7:0] t, input int n);
    for (int p = 0; p < n; p++) begin
      if (p == 0) beat(aF[p], bF[p], 1, 1, m, t);
      else        beat(aF[p], bF[p], 0, 0, 2'($urandom), 8'($urandom));
    end
  endtask

  task automatic makeFrame(input int kind);
    for (int p = 0; p < NP; p++) begin
      aF[p] = PW'($urandom);
      bF[p] = (kind == 2) ? aF[p] ^ (PW'($urandom) & 24'h070707) : aF[p];
    end
    if (kind == 1) begin
      aF[5*H + 10] = 24'h102030;
      bF[5*H + 10] = 24'h102031;
    end
  endtask

  task automatic drain();
    int n = 0;
    idleBus();
    while ((expQ.size() != 0 || cntQ.size() != 0) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    checkEq("drain_exp", 64'(expQ.size()), 64'd0);
    checkEq("drain_cnt", 64'(cntQ.size()), 64'd0);
    expQ.delete();
    cntQ.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkEq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    checkEq({tag, "_out_sof"}, 64'(bus.out_sof), 64'd0);
    checkEq({tag, "_out_eol"}, 64'(bus.out_eol), 64'd0);
    checkEq({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
    checkEq({tag, "_count_valid"}, 64'(count_valid), 64'd0);
    checkEq({tag, "_diff_count"}, 64'(diff_count), 64'd0);
    checkEq({tag, "_sync_err"}, 64'(sync_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idleBus();
    bus.a_data = '0; bus.b_data = '0;
    #1;
    checkAllZero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    makeFrame(0); sendFrame(2'd0, 8'd0, NP); drain();
    $display("frame identical mode0 thr0 sent");
    makeFrame(1); sendFrame(2'd0, 8'd0, NP); drain();
    $display("frame one-diff mode0 thr0 sent");
    sendFrame(2'd0, 8'd1, NP); drain();
    $display("frame one-diff mode0 thr1 sent");
    sendFrame(2'd2, 8'd0, NP); drain();
    $display("frame one-diff mode2 thr0 sent");

    stall = 1;
    makeFrame(2); sendFrame(2'd3, 8'd4, NP); drain();
    $display("frame random mode3 thr4 with stalls sent");
    makeFrame(2); sendFrame(2'd1, 8'd2, NP); drain();
    $display("frame random mode1 thr2 with stalls sent");

    // Abort a frame with a new sof partway through.
    makeFrame(2); sendFrame(2'd0, 8'd3, 50);
    makeFrame(2); sendFrame(2'd0, 8'd3, NP); drain();
    $display("aborted frame then full frame sent");

    // IDLE: beats without sof are consumed and dropped.
    for (int i = 0; i < 5; i++) beat(24'h111111, 24'h222222, 0, 0, 2'd0, 8'd0);
    // Join: one stream alone is never consumed, so no frame may start.
    bus.a_valid = 1; bus.a_sof = 1; bus.b_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    idleBus(); bus.b_valid = 1; bus.b_sof = 1;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) beat(24'h333333, 24'h444444, 0, 0, 2'd0, 8'd0);
    drain();
    $display("idle discard and join checks sent");

    checkEq("sync_err_before", 64'(sync_err), 64'd0);
    makeFrame(2);
    beat(aF[0], bF[0], 1, 0, 2'd2, 8'd0);
    for (int p = 1; p < 20; p++) beat(aF[p], bF[p], 0, 0, 2'd1, 8'd9);
    checkEq("sync_err_set", 64'(sync_err), 64'd1);
    sendFrame(2'd0, 8'd1, 30);
    checkEq("sync_err_sticky", 64'(sync_err), 64'd1);
    idleBus();
    rst_n = 0;
    #1;
    checkAllZero("midreset");
    expQ.delete(); cntQ.delete(); active = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) beat(24'h555555, 24'h666666, 0, 0, 2'd0, 8'd0);
    stall = 0;
    makeFrame(2); sendFrame(2'd2, 8'd0, NP); drain();
    checkEq("sync_err_after_reset", 64'(sync_err), 64'd0);
    $display("sync_err and mid-frame reset sequence sent");

    checkEq("count_valid_pulses", 64'(cvSeen), 64'(framesDone));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
